// File: rtl/ltssm_event_logger.sv
// Multi-link LTSSM trace logger: samples each link, turns state changes into timestamped events.
// Events pass through per-link pending slots, a round-robin arbiter and a FWFT FIFO.
// Optional stuck detection is enabled with `define LTSSM_LOG_STUCK_DET_EN.
module ltssm_event_logger #(
   parameter int NUM_LINKS   = 2,
   parameter int LTSSM_W     = 6,
   parameter int TS_W        = 32,
   parameter int FIFO_DEPTH  = 16,
   parameter int STUCK_LIMIT = 1000000,
   parameter logic [LTSSM_W-1:0] L0_CODE = LTSSM_W'(6'h11),
   localparam int LINK_W = (NUM_LINKS > 1) ? $clog2(NUM_LINKS) : 1,
   localparam int PTR_W  = $clog2(FIFO_DEPTH),
   localparam int LVL_W  = PTR_W + 1
) (
   input  logic                           clk_host_1p0g,
   input  logic                           rst_host_1p0g,
   input  logic [NUM_LINKS*LTSSM_W-1:0]   ltssm_state,
   input  logic [NUM_LINKS*3-1:0]         link_speed,
   input  logic [NUM_LINKS*3-1:0]         link_width,
   output logic                           evt_valid,
   input  logic                           evt_ready,
   output logic [LINK_W-1:0]              evt_link,
   output logic [LTSSM_W-1:0]             evt_old_state,
   output logic [LTSSM_W-1:0]             evt_new_state,
   output logic [2:0]                     evt_speed,
   output logic [2:0]                     evt_width,
   output logic [TS_W-1:0]                evt_ts,
   output logic [LVL_W-1:0]               fifo_level,
   output logic [15:0]                    drop_cnt,
   output logic [NUM_LINKS-1:0]           link_stuck
);

   typedef struct packed {
      logic [LINK_W-1:0]  link;
      logic [LTSSM_W-1:0] old_st;
      logic [LTSSM_W-1:0] new_st;
      logic [2:0]         speed;
      logic [2:0]         width;
      logic [TS_W-1:0]    ts;
   } evt_t;

   function automatic logic [LINK_W-1:0] rr_idx(input logic [LINK_W-1:0] base, input int off);
      int j;
      j = int'(base) + off;
      if (j >= NUM_LINKS) j = j - NUM_LINKS;
      return LINK_W'(j);
   endfunction

   logic [TS_W-1:0]              ts_q, ts_d;
   logic [NUM_LINKS*LTSSM_W-1:0] smp_state_q;
   logic [NUM_LINKS*3-1:0]       smp_speed_q, smp_width_q;
   logic [TS_W-1:0]              ts_s_q;
   logic                         smp_vld_q;
   logic                         prime_q, prime_d;
   logic [LTSSM_W-1:0]           prev_q [NUM_LINKS];
   logic [LTSSM_W-1:0]           prev_d [NUM_LINKS];
   logic [NUM_LINKS-1:0]         pend_q, pend_d;
   evt_t                         pend_ent_q [NUM_LINKS];
   evt_t                         pend_ent_d [NUM_LINKS];
   logic [LINK_W-1:0]            rr_q, rr_d;
   logic [15:0]                  drop_q, drop_d;
   logic [NUM_LINKS-1:0]         chg;

   evt_t                         mem_q [FIFO_DEPTH];
   evt_t                         mem_d [FIFO_DEPTH];
   evt_t                         last_q, last_d;
   evt_t                         head;
   logic [PTR_W-1:0]             wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [LVL_W-1:0]             cnt_q, cnt_d;
   logic                         fifo_full, push, pop;
   logic                         gnt_vld;
   logic [LINK_W-1:0]            gnt_idx;

   assign ts_d      = ts_q + TS_W'(1);
   assign fifo_full = (cnt_q == LVL_W'(FIFO_DEPTH));
   assign pop       = (cnt_q != '0) && evt_ready;
   assign push      = gnt_vld;

   always_comb begin
      chg = '0;
      for (int i = 0; i < NUM_LINKS; i++) begin
         chg[i] = smp_vld_q && !prime_q &&
                  (smp_state_q[i*LTSSM_W +: LTSSM_W] != prev_q[i]);
      end
   end

   // Fullness is judged on the registered count, so a same-cycle pop never frees a slot.
   always_comb begin
      gnt_vld = 1'b0;
      gnt_idx = '0;
      for (int k = 0; k < NUM_LINKS; k++) begin
         if (!gnt_vld && !fifo_full && pend_q[rr_idx(rr_q, k)]) begin
            gnt_vld = 1'b1;
            gnt_idx = rr_idx(rr_q, k);
         end
      end
      rr_d = gnt_vld ? rr_idx(gnt_idx, 1) : rr_q;
   end

   always_comb begin
      prime_d    = prime_q;
      prev_d     = prev_q;
      pend_d     = pend_q;
      pend_ent_d = pend_ent_q;
      drop_d     = drop_q;
      if (push) pend_d[gnt_idx] = 1'b0;
      if (smp_vld_q && prime_q) begin
         prime_d = 1'b0;
         for (int i = 0; i < NUM_LINKS; i++) prev_d[i] = smp_state_q[i*LTSSM_W +: LTSSM_W];
      end
      for (int i = 0; i < NUM_LINKS; i++) begin
         if (chg[i]) begin
            prev_d[i] = smp_state_q[i*LTSSM_W +: LTSSM_W];
            pend_d[i] = 1'b1;
            pend_ent_d[i].new_st = smp_state_q[i*LTSSM_W +: LTSSM_W];
            pend_ent_d[i].speed  = smp_speed_q[i*3 +: 3];
            pend_ent_d[i].width  = smp_width_q[i*3 +: 3];
            pend_ent_d[i].ts     = ts_s_q;
            if (pend_q[i] && !(push && gnt_idx == LINK_W'(i))) begin
               // Overwrite keeps the original old_state so the merged event spans both changes.
               if (drop_d != 16'hFFFF) drop_d = drop_d + 16'd1;
            end else begin
               pend_ent_d[i].link   = LINK_W'(i);
               pend_ent_d[i].old_st = prev_q[i];
            end
         end
      end
   end

   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      cnt_d    = cnt_q;
      last_d   = last_q;
      if (push) begin
         mem_d[wr_ptr_q] = pend_ent_q[gnt_idx];
         wr_ptr_d        = wr_ptr_q + PTR_W'(1);
      end
      if (pop) begin
         last_d   = mem_q[rd_ptr_q];
         rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      if (push && !pop)      cnt_d = cnt_q + LVL_W'(1);
      else if (!push && pop) cnt_d = cnt_q - LVL_W'(1);
   end

   // When empty the head shows the last popped entry, so fields hold their value.
   assign head          = (cnt_q != '0) ? mem_q[rd_ptr_q] : last_q;
   assign evt_valid     = (cnt_q != '0);
   assign evt_link      = head.link;
   assign evt_old_state = head.old_st;
   assign evt_new_state = head.new_st;
   assign evt_speed     = head.speed;
   assign evt_width     = head.width;
   assign evt_ts        = head.ts;
   assign fifo_level    = cnt_q;
   assign drop_cnt      = drop_q;

   always_ff @(posedge clk_host_1p0g) begin
      if (rst_host_1p0g) begin
         ts_q        <= '0;
         smp_state_q <= '0;
         smp_speed_q <= '0;
         smp_width_q <= '0;
         ts_s_q      <= '0;
         smp_vld_q   <= 1'b0;
         prime_q     <= 1'b1;
         pend_q      <= '0;
         rr_q        <= '0;
         drop_q      <= '0;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         cnt_q       <= '0;
         last_q      <= '0;
         for (int i = 0; i < NUM_LINKS; i++) begin
            prev_q[i]     <= '0;
            pend_ent_q[i] <= '0;
         end
      end else begin
         ts_q        <= ts_d;
         smp_state_q <= ltssm_state;
         smp_speed_q <= link_speed;
         smp_width_q <= link_width;
         ts_s_q      <= ts_q;
         smp_vld_q   <= 1'b1;
         prime_q     <= prime_d;
         pend_q      <= pend_d;
         rr_q        <= rr_d;
         drop_q      <= drop_d;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         cnt_q       <= cnt_d;
         last_q      <= last_d;
         prev_q      <= prev_d;
         pend_ent_q  <= pend_ent_d;
      end
   end

   always_ff @(posedge clk_host_1p0g) begin
      mem_q <= mem_d;
   end

`ifdef LTSSM_LOG_STUCK_DET_EN
   localparam int DW_W = $clog2(STUCK_LIMIT + 1);

   // Dwell is a down-counter of cycles remaining; terminal count 0 means the limit was reached.
   logic [DW_W-1:0]      dwell_rem_q [NUM_LINKS];
   logic [DW_W-1:0]      dwell_rem_d [NUM_LINKS];
   logic [NUM_LINKS-1:0] stuck_q, stuck_d;

   always_comb begin
      dwell_rem_d = dwell_rem_q;
      stuck_d     = stuck_q;
      if (smp_vld_q) begin
         for (int i = 0; i < NUM_LINKS; i++) begin
            if (prime_q || chg[i]) dwell_rem_d[i] = DW_W'(STUCK_LIMIT);
            else if (dwell_rem_q[i] != '0) dwell_rem_d[i] = dwell_rem_q[i] - DW_W'(1);
            stuck_d[i] = (dwell_rem_d[i] == '0) &&
                         (smp_state_q[i*LTSSM_W +: LTSSM_W] != L0_CODE);
         end
      end
   end

   always_ff @(posedge clk_host_1p0g) begin
      if (rst_host_1p0g) begin
         stuck_q <= '0;
         for (int i = 0; i < NUM_LINKS; i++) dwell_rem_q[i] <= DW_W'(STUCK_LIMIT);
      end else begin
         stuck_q     <= stuck_d;
         dwell_rem_q <= dwell_rem_d;
      end
   end

   assign link_stuck = stuck_q;
`else
   assign link_stuck = '0;
`endif

endmodule

// File: tb/tb_ltssm_event_logger.sv
// Directed bench for ltssm_event_logger: latency, round-robin order, overwrite/drop,
// timestamp wrap, stuck detection (when LTSSM_LOG_STUCK_DET_EN is defined) and reset.
module tb_ltssm_event_logger;

   logic        clk = 1'b0;
   logic        rst;
   logic [11:0] ltssm_state;
   logic [5:0]  link_speed;
   logic [5:0]  link_width;
   logic        evt_valid;
   logic        evt_ready;
   logic [0:0]  evt_link;
   logic [5:0]  evt_old_state;
   logic [5:0]  evt_new_state;
   logic [2:0]  evt_speed;
   logic [2:0]  evt_width;
   logic [7:0]  evt_ts;
   logic [4:0]  fifo_level;
   logic [15:0] drop_cnt;
   logic [1:0]  link_stuck;

   int checks   = 0;
   int failures = 0;
   logic [7:0] tb_ts;

   ltssm_event_logger #(
      .NUM_LINKS(2), .LTSSM_W(6), .TS_W(8), .FIFO_DEPTH(16),
      .STUCK_LIMIT(8), .L0_CODE(6'h11)
   ) dut (
      .clk_host_1p0g(clk),
      .rst_host_1p0g(rst),
      .ltssm_state(ltssm_state),
      .link_speed(link_speed),
      .link_width(link_width),
      .evt_valid(evt_valid),
      .evt_ready(evt_ready),
      .evt_link(evt_link),
      .evt_old_state(evt_old_state),
      .evt_new_state(evt_new_state),
      .evt_speed(evt_speed),
      .evt_width(evt_width),
      .evt_ts(evt_ts),
      .fifo_level(fifo_level),
      .drop_cnt(drop_cnt),
      .link_stuck(link_stuck)
   );

   always #5 clk = ~clk;

   // Reference timestamp: value the DUT counter holds between edges.
   always @(posedge clk) begin
      if (rst) tb_ts <= 8'd0;
      else     tb_ts <= tb_ts + 8'd1;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic set_link(input int i, input logic [5:0] st);
      ltssm_state[i*6 +: 6] = st;
   endtask

   task automatic pop_chk(input string tag, input logic exp_link, input logic [5:0] eo,
                          input logic [5:0] en, input logic [7:0] ets,
                          input logic [2:0] esp, input logic [2:0] ew);
      int n;
      n = 0;
      while (!evt_valid && n < 20) begin
         @(negedge clk);
         n++;
      end
      chk({tag, "_valid"}, 32'(evt_valid), 32'd1);
      chk({tag, "_link"},  32'(evt_link), 32'(exp_link));
      chk({tag, "_old"},   32'(evt_old_state), 32'(eo));
      chk({tag, "_new"},   32'(evt_new_state), 32'(en));
      chk({tag, "_ts"},    32'(evt_ts), 32'(ets));
      chk({tag, "_speed"}, 32'(evt_speed), 32'(esp));
      chk({tag, "_width"}, 32'(evt_width), 32'(ew));
      evt_ready = 1'b1;
      @(posedge clk);
      @(negedge clk);
      evt_ready = 1'b0;
   endtask

   logic [7:0] t0, t1;
   logic [5:0] st_arr [21];
   logic [7:0] ts_arr [21];
   int         n;

   initial begin
      rst         = 1'b1;
      ltssm_state = '0;
      link_speed  = '0;
      link_width  = '0;
      evt_ready   = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_valid", 32'(evt_valid), 32'd0);
      chk("rst_level", 32'(fifo_level), 32'd0);
      chk("rst_drop",  32'(drop_cnt), 32'd0);
      chk("rst_ts",    32'(evt_ts), 32'd0);
      chk("rst_stuck", 32'(link_stuck), 32'd0);
      rst = 1'b0;

      // Steady link0 = 00: priming sample only, no event
      repeat (6) @(negedge clk);
      chk("idle_valid", 32'(evt_valid), 32'd0);
      chk("idle_level", 32'(fifo_level), 32'd0);
      chk("idle_drop",  32'(drop_cnt), 32'd0);

      // Single change, exact 3-cycle latency
      t0 = tb_ts;
      set_link(0, 6'h01);
      link_speed[2:0] = 3'd2;
      link_width[2:0] = 3'd4;
      @(negedge clk);
      chk("lat_c1", 32'(evt_valid), 32'd0);
      @(negedge clk);
      chk("lat_c2", 32'(evt_valid), 32'd0);
      @(negedge clk);
      chk("lat_c3", 32'(evt_valid), 32'd1);
      pop_chk("ev_l0", 1'b0, 6'h00, 6'h01, t0, 3'd2, 3'd4);

      // Link1 alone; pointer returns to 0
      t0 = tb_ts;
      set_link(1, 6'h02);
      pop_chk("ev_l1", 1'b1, 6'h00, 6'h02, t0, 3'd0, 3'd0);

      // Both change with RR=0: link0 first, equal timestamps
      t0 = tb_ts;
      set_link(0, 6'h03);
      set_link(1, 6'h04);
      pop_chk("rr0_a", 1'b0, 6'h01, 6'h03, t0, 3'd2, 3'd4);
      pop_chk("rr0_b", 1'b1, 6'h02, 6'h04, t0, 3'd0, 3'd0);

      // Link0 alone moves RR to 1, then both change: link1 first
      t0 = tb_ts;
      set_link(0, 6'h05);
      pop_chk("rr_set", 1'b0, 6'h03, 6'h05, t0, 3'd2, 3'd4);
      t0 = tb_ts;
      set_link(0, 6'h06);
      set_link(1, 6'h07);
      pop_chk("rr1_a", 1'b1, 6'h04, 6'h07, t0, 3'd0, 3'd0);
      pop_chk("rr1_b", 1'b0, 6'h05, 6'h06, t0, 3'd2, 3'd4);

      // Speed-only change: no event
      link_speed[2:0] = 3'd5;
      repeat (6) @(negedge clk);
      chk("spd_only_valid", 32'(evt_valid), 32'd0);
      chk("spd_only_level", 32'(fifo_level), 32'd0);

      // Timestamp wrap with back-to-back changes (pending set + grant same cycle)
      n = 0;
      while (tb_ts != 8'd254 && n < 600) begin
         @(negedge clk);
         n++;
      end
      set_link(0, 6'h09);
      @(negedge clk);
      set_link(0, 6'h0A);
      @(negedge clk);
      set_link(0, 6'h0B);
      pop_chk("wrap_a", 1'b0, 6'h06, 6'h09, 8'd254, 3'd5, 3'd4);
      pop_chk("wrap_b", 1'b0, 6'h09, 6'h0A, 8'd255, 3'd5, 3'd4);
      pop_chk("wrap_c", 1'b0, 6'h0A, 6'h0B, 8'd0,   3'd5, 3'd4);
      chk("wrap_drop", 32'(drop_cnt), 32'd0);

      // Fill FIFO with ready low: 16 stored, 17th pending, 18..20 overwrite it
      st_arr[0] = 6'h0B;
      for (int k = 1; k <= 20; k++) begin
         st_arr[k] = 6'h20 + 6'(k);
         ts_arr[k] = tb_ts;
         set_link(0, st_arr[k]);
         repeat (2) @(negedge clk);
      end
      repeat (6) @(negedge clk);
      chk("full_level", 32'(fifo_level), 32'd16);
      chk("full_drop",  32'(drop_cnt), 32'd3);
      chk("full_head",  32'(evt_new_state), 32'(st_arr[1]));
      for (int k = 1; k <= 16; k++) begin
         pop_chk("drain", 1'b0, st_arr[k-1], st_arr[k], ts_arr[k], 3'd5, 3'd4);
      end
      pop_chk("merged", 1'b0, st_arr[16], st_arr[20], ts_arr[20], 3'd5, 3'd4);
      repeat (4) @(negedge clk);
      chk("drained_level", 32'(fifo_level), 32'd0);
      chk("drained_valid", 32'(evt_valid), 32'd0);
      chk("drained_hold",  32'(evt_new_state), 32'(st_arr[20]));
      chk("drained_drop",  32'(drop_cnt), 32'd3);

`ifdef LTSSM_LOG_STUCK_DET_EN
      rst = 1'b1;
      set_link(0, 6'h11);
      set_link(1, 6'h05);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      repeat (4) @(negedge clk);
      chk("stuck_early", 32'(link_stuck[1]), 32'd0);
      n = 0;
      while (!link_stuck[1] && n < 30) begin
         @(negedge clk);
         n++;
      end
      chk("stuck_set", 32'(link_stuck[1]), 32'd1);
      chk("stuck_l0_link", 32'(link_stuck[0]), 32'd0);
      set_link(1, 6'h11);
      repeat (4) @(negedge clk);
      chk("stuck_clear", 32'(link_stuck[1]), 32'd0);
      repeat (15) @(negedge clk);
      chk("stuck_l0_hold", 32'(link_stuck), 32'd0);
`else
      chk("stuck_disabled", 32'(link_stuck), 32'd0);
`endif

      // Reset while an event sits in the FIFO
      set_link(0, 6'h3F);
      repeat (4) @(negedge clk);
      chk("pre_rst_valid", 32'(evt_valid), 32'd1);
      rst = 1'b1;
      @(negedge clk);
      chk("mid_rst_level", 32'(fifo_level), 32'd0);
      chk("mid_rst_valid", 32'(evt_valid), 32'd0);
      chk("mid_rst_drop",  32'(drop_cnt), 32'd0);
      chk("mid_rst_ts",    32'(evt_ts), 32'd0);
      rst = 1'b0;
      repeat (2) @(negedge clk);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
